vx_alu_bitcnt: RTL and testbench



---
 rtl/vx_alu_bitcnt_pkg.sv | 38 +++
 rtl/vx_bitcnt_lane.sv | 44 ++++
 rtl/vx_alu_bitcnt.sv | 142 ++++++++++++++
 tb/tb_vx_alu_bitcnt.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_alu_bitcnt_pkg.sv
// Shared types and encodings for the Zbb bit-count ALU processing element.
package vx_alu_bitcnt_pkg;

   localparam int XLEN    = 32;
   localparam int UUID_W  = 44;
   localparam int NW_W    = 2;
   localparam int NR_W    = 5;
   localparam int PID_W   = 1;
   localparam int CNT_W   = $clog2(XLEN + 1);

   typedef logic [3:0] inst_alu_t;

   localparam inst_alu_t INST_ALU_CPOP = 4'hA;
   localparam inst_alu_t INST_ALU_CLZ  = 4'hB;
   localparam inst_alu_t INST_ALU_CTZ  = 4'hC;

   // Slot of this PE behind the ALU unit's per-block PE switch.
   localparam int PE_IDX_BCNT = 3;

   // Header shared by alu_exe_t and alu_res_t; lane payloads travel on separate ports.
   typedef struct packed {
      logic [UUID_W-1:0] uuid;
      logic [NW_W-1:0]   wid;
      logic [XLEN-1:0]   pc;
      logic [NR_W-1:0]   rd;
      logic              wb;
      logic [PID_W-1:0]  pid;
      logic              sop;
      logic              eop;
   } alu_hdr_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } bcnt_state_t;

endpackage

// File: rtl/vx_bitcnt_lane.sv
// Combinational per-lane CPOP / CLZ / CTZ; disabled lanes and unknown ops yield 0.
module vx_bitcnt_lane
   import vx_alu_bitcnt_pkg::*;
(
   input  inst_alu_t         op_i,
   input  logic              en_i,
   input  logic [XLEN-1:0]   opnd_i,
   output logic [XLEN-1:0]   cnt_o
);

   logic [CNT_W-1:0] pop;
   logic [CNT_W-1:0] clz;
   logic [CNT_W-1:0] ctz;
   logic [CNT_W-1:0] cnt;

   always_comb begin
      pop = '0;
      clz = CNT_W'(XLEN);
      ctz = CNT_W'(XLEN);
      // Upward scan: the highest set bit is the last to overwrite clz.
      for (int i = 0; i < XLEN; i++) begin
         pop = pop + CNT_W'(opnd_i[i]);
         if (opnd_i[i]) clz = CNT_W'(XLEN - 1 - i);
      end
      for (int i = XLEN - 1; i >= 0; i--) begin
         if (opnd_i[i]) ctz = CNT_W'(i);
      end
   end

   always_comb begin
      cnt = '0;
      if (en_i) begin
         case (op_i)
            INST_ALU_CPOP: cnt = pop;
            INST_ALU_CLZ:  cnt = clz;
            INST_ALU_CTZ:  cnt = ctz;
            default:       cnt = '0;
         endcase
      end
   end

   assign cnt_o = XLEN'(cnt);

endmodule

// File: rtl/vx_alu_bitcnt.sv
// Multi-cycle bit-count PE: latches one request, evaluates LANE_BATCH lanes per
// cycle, then holds a registered result until the consumer accepts it.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a request, no result pending
// BUSY    | evaluating lane batches into the result register
// DONE    | result valid and held; accepts a back-to-back request
module vx_alu_bitcnt
   import vx_alu_bitcnt_pkg::*;
#(
   parameter string INSTANCE_ID = "",
   parameter int    NUM_LANES   = 4,
   parameter int    LANE_BATCH  = 1
) (
   input  logic                             clk,
   input  logic                             reset,

   input  logic                             execute_valid_i,
   output logic                             execute_ready_o,
   input  inst_alu_t                        execute_op_i,
   input  alu_hdr_t                         execute_hdr_i,
   input  logic [NUM_LANES-1:0]             execute_tmask_i,
   input  logic [NUM_LANES-1:0][XLEN-1:0]   execute_rs1_i,

   output logic                             result_valid_o,
   input  logic                             result_ready_i,
   output alu_hdr_t                         result_hdr_o,
   output logic [NUM_LANES-1:0]             result_tmask_o,
   output logic [NUM_LANES-1:0][XLEN-1:0]   result_data_o
);

   localparam int NUM_BATCH = NUM_LANES / LANE_BATCH;
   localparam int BATCH_W   = (NUM_BATCH > 1) ? $clog2(NUM_BATCH) : 1;
   localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(NUM_BATCH - 1);

   if ((NUM_LANES % LANE_BATCH) != 0) begin : g_bad_cfg
      $error("%s: LANE_BATCH must divide NUM_LANES", INSTANCE_ID);
   end

   bcnt_state_t                     state_q, state_d;
   logic [BATCH_W-1:0]              batch_q, batch_d;
   inst_alu_t                       op_q, op_d;
   alu_hdr_t                        hdr_q, hdr_d;
   logic [NUM_LANES-1:0]            tmask_q, tmask_d;
   logic [NUM_LANES-1:0][XLEN-1:0]  rs1_q, rs1_d;
   logic [NUM_LANES-1:0][XLEN-1:0]  data_q, data_d;

   logic                            accept;
   logic                            exe_ready;
   logic [LANE_W-1:0]               lane_idx [LANE_BATCH];
   logic [XLEN-1:0]                 lane_cnt [LANE_BATCH];

   for (genvar b = 0; b < LANE_BATCH; b++) begin : g_lane
      assign lane_idx[b] = LANE_W'(int'(batch_q) * LANE_BATCH + b);

      vx_bitcnt_lane u_lane (
         .op_i   (op_q),
         .en_i   (tmask_q[lane_idx[b]]),
         .opnd_i (rs1_q[lane_idx[b]]),
         .cnt_o  (lane_cnt[b])
      );
   end

   always_comb begin
      state_d   = state_q;
      batch_d   = batch_q;
      op_d      = op_q;
      hdr_d     = hdr_q;
      tmask_d   = tmask_q;
      rs1_d     = rs1_q;
      data_d    = data_q;
      exe_ready = 1'b0;
      accept    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            exe_ready = 1'b1;
            accept    = execute_valid_i;
         end
         ST_BUSY: begin
            for (int b = 0; b < LANE_BATCH; b++) begin
               data_d[lane_idx[b]] = lane_cnt[b];
            end
            if (batch_q == LAST_BATCH) begin
               state_d = ST_DONE;
               batch_d = '0;
            end else begin
               batch_d = batch_q + BATCH_W'(1);
            end
         end
         ST_DONE: begin
            // Accepting the next request only when the result leaves keeps
            // the held result stable under backpressure.
            exe_ready = result_ready_i;
            if (result_ready_i) begin
               state_d = ST_IDLE;
               accept  = execute_valid_i;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         state_d = ST_BUSY;
         batch_d = '0;
         op_d    = execute_op_i;
         hdr_d   = execute_hdr_i;
         tmask_d = execute_tmask_i;
         rs1_d   = execute_rs1_i;
         data_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         batch_q <= '0;
         op_q    <= '0;
         hdr_q   <= '0;
         tmask_q <= '0;
         rs1_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         batch_q <= batch_d;
         op_q    <= op_d;
         hdr_q   <= hdr_d;
         tmask_q <= tmask_d;
         rs1_q   <= rs1_d;
         data_q  <= data_d;
      end
   end

   assign execute_ready_o = exe_ready;
   assign result_valid_o  = (state_q == ST_DONE);
   assign result_hdr_o    = hdr_q;
   assign result_tmask_o  = tmask_q;
   assign result_data_o   = data_q;

endmodule

// File: tb/tb_vx_alu_bitcnt.sv
// Scoreboard bench for vx_alu_bitcnt: two instances (LANE_BATCH=1 and 2).
module tb_vx_alu_bitcnt;
   import vx_alu_bitcnt_pkg::*;

   typedef logic [3:0][XLEN-1:0] vec_t;
   typedef struct packed {
      alu_hdr_t   hdr;
      logic [3:0] tm;
      vec_t       data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic ev0 = 0, ev1 = 0, er0, er1, rv0, rv1;
   logic rr0 = 1, rr1 = 1;
   inst_alu_t op0 = '0, op1 = '0;
   alu_hdr_t hdr0 = '0, hdr1 = '0, rh0, rh1;
   logic [3:0] tm0 = '0, tm1 = '0, rt0, rt1;
   vec_t rs0 = '0, rs1 = '0, rd0, rd1;

   vx_alu_bitcnt #(.INSTANCE_ID("bcnt0"), .NUM_LANES(4), .LANE_BATCH(1)) dut (
      .clk(clk), .reset(reset),
      .execute_valid_i(ev0), .execute_ready_o(er0), .execute_op_i(op0),
      .execute_hdr_i(hdr0), .execute_tmask_i(tm0), .execute_rs1_i(rs0),
      .result_valid_o(rv0), .result_ready_i(rr0), .result_hdr_o(rh0),
      .result_tmask_o(rt0), .result_data_o(rd0));

   vx_alu_bitcnt #(.INSTANCE_ID("bcnt1"), .NUM_LANES(4), .LANE_BATCH(2)) dut2 (
      .clk(clk), .reset(reset),
      .execute_valid_i(ev1), .execute_ready_o(er1), .execute_op_i(op1),
      .execute_hdr_i(hdr1), .execute_tmask_i(tm1), .execute_rs1_i(rs1),
      .result_valid_o(rv1), .result_ready_i(rr1), .result_hdr_o(rh1),
      .result_tmask_o(rt1), .result_data_o(rd1));

   int errors = 0;
   int checks = 0;
   exp_t exp_q0[$], exp_q1[$];
   int fire_q0[$], fire_q1[$];
   int cyc[2] = '{0, 0};
   bit prev_v[2] = '{0, 0};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic alu_hdr_t mkhdr(input int n, input logic wb);
      alu_hdr_t h;
      h.uuid = 44'h0AB_0000_0000 + 44'(n);
      h.wid  = 2'(n);
      h.pc   = 32'h8000_0000 + 32'(n * 4);
      h.rd   = 5'(n + 3);
      h.wb   = wb;
      h.pid  = 1'(n);
      h.sop  = 1'b1;
      h.eop  = 1'(n);
      return h;
   endfunction

   task automatic mon(input int s, input logic ev, er, rv, rr, input alu_hdr_t rh,
                      input logic [3:0] rt, input vec_t rd);
      exp_t e;
      int f;
      int lat;
      cyc[s]++;
      lat = (s == 0) ? 5 : 3;
      if (ev && er) begin
         if (s == 0) fire_q0.push_back(cyc[s]); else fire_q1.push_back(cyc[s]);
      end
      if (rv && !prev_v[s]) begin
         if ((s == 0 ? fire_q0.size() : fire_q1.size()) == 0) begin
            chk($sformatf("d%0d_valid_without_request", s), 1, 0);
         end else begin
            f = (s == 0) ? fire_q0.pop_front() : fire_q1.pop_front();
            chk($sformatf("d%0d_latency", s), cyc[s] - f, lat);
         end
      end
      if (rv) begin
         chk($sformatf("d%0d_exe_ready_in_done", s), er, rr);
         if ((s == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            chk($sformatf("d%0d_unexpected_result", s), 1, 0);
         end else begin
            e = (s == 0) ? exp_q0[0] : exp_q1[0];
            for (int i = 0; i < 4; i++)
               chk($sformatf("d%0d_data%0d", s, i), rd[i], e.data[i]);
            chk($sformatf("d%0d_hdr", s), rh, e.hdr);
            chk($sformatf("d%0d_tmask", s), rt, e.tm);
            if (rr) begin
               if (s == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            end
         end
      end
      prev_v[s] = rv;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         prev_v[0] = 0;
         prev_v[1] = 0;
      end else begin
         mon(0, ev0, er0, rv0, rr0, rh0, rt0, rd0);
         mon(1, ev1, er1, rv1, rr1, rh1, rt1, rd1);
      end
   end

   // Drives one request and returns after its fire edge; waits = negedges until ready.
   task automatic send(input int s, input inst_alu_t op, input alu_hdr_t h,
                       input logic [3:0] tm, input vec_t rs, input vec_t expd,
                       output int waits);
      bit got = 0;
      exp_t e;
      waits = 0;
      if (s == 0) begin ev0 = 1; op0 = op; hdr0 = h; tm0 = tm; rs0 = rs; end
      else        begin ev1 = 1; op1 = op; hdr1 = h; tm1 = tm; rs1 = rs; end
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         waits++;
         got = (s == 0) ? er0 : er1;
      end
      if (!got) chk($sformatf("d%0d_request_accepted", s), 0, 1);
      e.hdr = h; e.tm = tm; e.data = expd;
      if (s == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      @(posedge clk);
      #1;
      if (s == 0) ev0 = 0; else ev1 = 0;
   endtask

   task automatic wait_valid(input int s);
      bit got = 0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         got = (s == 0) ? rv0 : rv1;
      end
      if (!got) chk($sformatf("d%0d_wait_valid_timeout", s), 0, 1);
   endtask

   task automatic drain();
      bit done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         done = (exp_q0.size() == 0) && (exp_q1.size() == 0);
      end
      if (!done) chk("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #3 reset = 1;
      #1;
      chk("reset_valid_async", rv0, 0);
      chk("reset_data_cleared", rd0, 0);
      exp_q0.delete();
      fire_q0.delete();
      @(posedge clk);
      #3 reset = 0;
      #1;
      chk("post_reset_exe_ready", er0, 1);
      @(posedge clk);
      #1;
   endtask

   vec_t v_cpop, v_edge, v_ones, v_a, v_b;
   int w;

   initial begin
      v_cpop = mk(32'hFFFF_FFFF, 32'h0, 32'h8000_0001, 32'h0F0F_0F0F);
      v_edge = mk(32'h0, 32'h1, 32'h8000_0000, 32'h0001_0000);
      v_ones = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      v_a    = mk(32'h8, 32'h100, 32'hFFFF_0000, 32'h3);
      v_b    = mk(32'h0000_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0080_0000);

      repeat (3) @(posedge clk);
      #3 reset = 0;
      @(negedge clk);
      chk("rst_valid0", rv0, 0);
      chk("rst_ready0", er0, 1);
      chk("rst_data0", rd0, 0);
      chk("rst_valid1", rv1, 0);
      chk("rst_ready1", er1, 1);
      @(posedge clk);
      #1;

      send(0, INST_ALU_CPOP, mkhdr(1, 1), 4'b1111, v_cpop, mk(32, 0, 2, 16), w);
      drain();
      send(0, INST_ALU_CLZ, mkhdr(2, 1), 4'b1111, v_edge, mk(32, 31, 0, 15), w);
      drain();
      send(0, INST_ALU_CTZ, mkhdr(3, 1), 4'b1111, v_edge, mk(32, 0, 31, 16), w);
      drain();
      send(0, INST_ALU_CPOP, mkhdr(6, 0), 4'b0101, v_ones, mk(32, 0, 32, 0), w);
      drain();
      send(0, 4'hF, mkhdr(7, 1), 4'b1111, v_ones, mk(0, 0, 0, 0), w);
      drain();

      // Backpressure followed by a back-to-back handshake.
      rr0 = 0;
      send(0, INST_ALU_CTZ, mkhdr(8, 1), 4'b1111, v_a, mk(3, 8, 16, 0), w);
      wait_valid(0);
      repeat (10) @(negedge clk);
      chk("stall_valid_held", rv0, 1);
      @(posedge clk);
      #1 rr0 = 1;
      send(0, INST_ALU_CLZ, mkhdr(9, 1), 4'b1111, v_b, mk(16, 31, 0, 8), w);
      chk("b2b_same_cycle", w, 1);
      drain();

      // Reset mid-BUSY, then a clean transaction.
      send(0, INST_ALU_CPOP, mkhdr(10, 1), 4'b1111, v_cpop, mk(32, 0, 2, 16), w);
      pulse_reset();
      send(0, INST_ALU_CTZ, mkhdr(11, 1), 4'b1011, v_a, mk(3, 8, 0, 0), w);
      drain();

      // Reset while a result is held in DONE.
      rr0 = 0;
      send(0, INST_ALU_CPOP, mkhdr(12, 1), 4'b1111, v_ones, mk(32, 32, 32, 32), w);
      wait_valid(0);
      pulse_reset();
      rr0 = 1;
      send(0, INST_ALU_CLZ, mkhdr(13, 1), 4'b1111, v_edge, mk(32, 31, 0, 15), w);
      drain();

      // LANE_BATCH=2 instance: same results, latency 3.
      send(1, INST_ALU_CPOP, mkhdr(1, 1), 4'b1111, v_cpop, mk(32, 0, 2, 16), w);
      drain();
      send(1, INST_ALU_CLZ, mkhdr(2, 1), 4'b1111, v_edge, mk(32, 31, 0, 15), w);
      drain();
      send(1, INST_ALU_CTZ, mkhdr(3, 1), 4'b0110, v_edge, mk(0, 0, 31, 0), w);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
